// File: rtl/memory_receive.sv
// Load-completion stage: keeps an in-order queue of issued loads and pairs each
// returning memory word with the oldest entry, then aligns/extends it into a registered writeback.
module memory_receive #(
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_BYTES      = DATA_WIDTH / 8,
  parameter int LOG2_NUM_BYTES = $clog2(NUM_BYTES),
  parameter int REG_BITS       = 5,
  parameter int QUEUE_DEPTH    = 4,
  localparam int PW = $clog2(QUEUE_DEPTH),
  localparam int CW = PW + 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      issue_valid,
  output logic                      issue_ready,
  input  logic [LOG2_NUM_BYTES-1:0] issue_offset,
  input  logic [LOG2_NUM_BYTES-1:0] issue_log2_bytes,
  input  logic                      issue_unsigned,
  input  logic [REG_BITS-1:0]       issue_rd,
  input  logic                      mem_valid,
  output logic                      mem_ready,
  input  logic [DATA_WIDTH-1:0]     mem_data,
  input  logic                      flush,
  output logic                      wb_valid,
  input  logic                      wb_ready,
  output logic [REG_BITS-1:0]       wb_rd,
  output logic [DATA_WIDTH-1:0]     wb_data,
  output logic [CW-1:0]             pending_count,
  output logic                      spurious_error
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // valid-side data must stay stable while valid && !ready.

  typedef struct packed {
    logic [LOG2_NUM_BYTES-1:0] offset;
    logic [LOG2_NUM_BYTES-1:0] size;
    logic                      uns;
    logic [REG_BITS-1:0]       rd;
  } entry_t;

  entry_t                queue_q [QUEUE_DEPTH];
  entry_t                queue_d [QUEUE_DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [CW-1:0]         drop_q, drop_d;
  logic                  wb_valid_q, wb_valid_d;
  logic [REG_BITS-1:0]   wb_rd_q, wb_rd_d;
  logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;
  logic                  spur_q, spur_d;

  logic [CW:0]           outstanding;
  logic                  push, accept, drop_acc, normal_pop, spurious;
  entry_t                head;
  logic [DATA_WIDTH-1:0] shifted, aligned;
  logic                  sign_bit;

  assign outstanding = {1'b0, count_q} + {1'b0, drop_q};
  assign issue_ready = (outstanding < (CW+1)'(QUEUE_DEPTH)) && !flush;
  assign mem_ready   = (drop_q != '0) || !wb_valid_q || wb_ready;

  assign push       = issue_valid && issue_ready;
  assign accept     = mem_valid && mem_ready;
  assign drop_acc   = accept && (drop_q != '0);
  assign normal_pop = accept && (drop_q == '0) && (count_q != '0);
  assign spurious   = accept && (drop_q == '0) && (count_q == '0);

  assign head    = queue_q[rd_ptr_q];
  assign shifted = mem_data >> {head.offset, 3'b000};

  // Sub-word sizes keep the low 8<<k bits and fill the rest from their top bit (or zero).
  always_comb begin
    aligned  = shifted;
    sign_bit = 1'b0;
    for (int k = 0; k < LOG2_NUM_BYTES; k++) begin
      if (head.size == LOG2_NUM_BYTES'(k)) begin
        sign_bit = head.uns ? 1'b0 : shifted[(8 << k) - 1];
        for (int i = 0; i < DATA_WIDTH; i++) begin
          if (i >= (8 << k)) aligned[i] = sign_bit;
        end
      end
    end
  end

  always_comb begin
    queue_d    = queue_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q + CW'(push) - CW'(normal_pop);
    drop_d     = drop_q - CW'(drop_acc);
    wb_valid_d = wb_valid_q;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    spur_d     = spur_q | spurious;

    if (push) begin
      queue_d[wr_ptr_q] = '{offset: issue_offset, size: issue_log2_bytes,
                            uns: issue_unsigned, rd: issue_rd};
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (normal_pop) rd_ptr_d = rd_ptr_q + PW'(1);

    if (normal_pop && !flush) begin
      wb_valid_d = 1'b1;
      wb_rd_d    = head.rd;
      wb_data_d  = aligned;
    end else if (wb_valid_q && wb_ready) begin
      wb_valid_d = 1'b0;
    end

    // Every still-pending load becomes a response to swallow; one popped now is swallowed too.
    if (flush) begin
      drop_d     = drop_q - CW'(drop_acc) + count_q - CW'(normal_pop);
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      wb_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) queue_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      drop_q     <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      spur_q     <= 1'b0;
    end else begin
      for (int i = 0; i < QUEUE_DEPTH; i++) queue_q[i] <= queue_d[i];
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      drop_q     <= drop_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      spur_q     <= spur_d;
    end
  end

  assign wb_valid       = wb_valid_q;
  assign wb_rd          = wb_rd_q;
  assign wb_data        = wb_data_q;
  assign pending_count  = count_q;
  assign spurious_error = spur_q;

endmodule

// File: tb/tb_memory_receive.sv
// Directed bench for memory_receive: hand-computed writebacks, backpressure, flush, spurious and reset.
module tb_memory_receive;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        issue_valid = 1'b0;
  logic        issue_ready;
  logic [1:0]  issue_offset = '0;
  logic [1:0]  issue_log2_bytes = '0;
  logic        issue_unsigned = 1'b0;
  logic [4:0]  issue_rd = '0;
  logic        mem_valid = 1'b0;
  logic        mem_ready;
  logic [31:0] mem_data = '0;
  logic        flush = 1'b0;
  logic        wb_valid;
  logic        wb_ready = 1'b1;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [2:0]  pending_count;
  logic        spurious_error;

  int n_checks = 0;
  int n_errors = 0;

  memory_receive dut (
    .clock(clock), .reset(reset),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_offset(issue_offset), .issue_log2_bytes(issue_log2_bytes),
    .issue_unsigned(issue_unsigned), .issue_rd(issue_rd),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_data(mem_data),
    .flush(flush),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .pending_count(pending_count), .spurious_error(spurious_error)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks run there too.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [1:0] off, input logic [1:0] sz, input logic uns,
                       input logic [4:0] rd);
    issue_valid = 1'b1; issue_offset = off; issue_log2_bytes = sz;
    issue_unsigned = uns; issue_rd = rd;
    step();
    issue_valid = 1'b0;
  endtask

  task automatic respond(input logic [31:0] d);
    mem_valid = 1'b1; mem_data = d;
    step();
    mem_valid = 1'b0;
  endtask

  initial begin
    #2;
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_wb_rd", 32'(wb_rd), 32'd0);
    check("rst_pending", 32'(pending_count), 32'd0);
    check("rst_spurious", 32'(spurious_error), 32'd0);
    check("rst_issue_ready", 32'(issue_ready), 32'd1);
    @(negedge clock);
    reset = 1'b1;
    step();

    // Signed byte at offset 2
    issue(2'd2, 2'd0, 1'b0, 5'd7);
    check("sb_pending", 32'(pending_count), 32'd1);
    respond(32'h1280_3456);
    check("sb_valid", 32'(wb_valid), 32'd1);
    check("sb_rd", 32'(wb_rd), 32'd7);
    check("sb_data", wb_data, 32'hFFFF_FF80);
    check("sb_pending0", 32'(pending_count), 32'd0);
    step();
    check("sb_retired", 32'(wb_valid), 32'd0);

    // Halfword unsigned / signed, word, unsigned byte, misaligned half
    issue(2'd2, 2'd1, 1'b1, 5'd3);
    respond(32'h8001_0000);
    check("uh_rd", 32'(wb_rd), 32'd3);
    check("uh_data", wb_data, 32'h0000_8001);
    issue(2'd2, 2'd1, 1'b0, 5'd4);
    respond(32'h8001_0000);
    check("sh_data", wb_data, 32'hFFFF_8001);
    issue(2'd0, 2'd2, 1'b0, 5'd9);
    respond(32'hDEAD_BEEF);
    check("word_data", wb_data, 32'hDEAD_BEEF);
    issue(2'd3, 2'd0, 1'b1, 5'd10);
    respond(32'h8012_3456);
    check("ub_data", wb_data, 32'h0000_0080);
    issue(2'd3, 2'd1, 1'b0, 5'd11);
    respond(32'h8000_0000);
    check("mis_half_data", wb_data, 32'h0000_0080);
    step();

    // Fill, overflow attempt, then drain four back-to-back
    for (int i = 0; i < 4; i++) issue(2'd0, 2'd2, 1'b0, 5'(12 + i));
    check("full_ready", 32'(issue_ready), 32'd0);
    check("full_pending", 32'(pending_count), 32'd4);
    issue(2'd0, 2'd2, 1'b0, 5'd30);
    check("full_ignored", 32'(pending_count), 32'd4);
    mem_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mem_data = 32'hA + 32'(i);
      step();
      check("drain_valid", 32'(wb_valid), 32'd1);
      check("drain_rd", 32'(wb_rd), 32'(12 + i));
      check("drain_data", wb_data, 32'hA + 32'(i));
    end
    mem_valid = 1'b0;
    check("drain_pending", 32'(pending_count), 32'd0);
    check("drain_ready", 32'(issue_ready), 32'd1);
    step();

    // Backpressure holds the writeback and blocks the second response
    wb_ready = 1'b0;
    issue(2'd0, 2'd2, 1'b0, 5'd20);
    issue(2'd0, 2'd2, 1'b0, 5'd21);
    mem_valid = 1'b1; mem_data = 32'h111;
    step();
    mem_data = 32'h222;
    #1;
    check("bp_mem_ready", 32'(mem_ready), 32'd0);
    step();
    step();
    check("bp_hold_rd", 32'(wb_rd), 32'd20);
    check("bp_hold_data", wb_data, 32'h111);
    check("bp_pending", 32'(pending_count), 32'd1);
    wb_ready = 1'b1;
    step();
    mem_valid = 1'b0;
    check("bp_second_rd", 32'(wb_rd), 32'd21);
    check("bp_second_data", wb_data, 32'h222);
    check("bp_second_valid", 32'(wb_valid), 32'd1);
    step();
    check("bp_done", 32'(wb_valid), 32'd0);

    // Flush with three pending: their responses vanish, the next load writes back
    for (int i = 0; i < 3; i++) issue(2'd0, 2'd2, 1'b0, 5'(1 + i));
    flush = 1'b1;
    #1;
    check("fl_ready_during", 32'(issue_ready), 32'd0);
    step();
    flush = 1'b0;
    check("fl_pending", 32'(pending_count), 32'd0);
    check("fl_wb_valid", 32'(wb_valid), 32'd0);
    issue(2'd0, 2'd2, 1'b0, 5'd5);
    check("fl_full", 32'(issue_ready), 32'd0);
    check("fl_pending1", 32'(pending_count), 32'd1);
    for (int i = 0; i < 3; i++) begin
      respond(32'hBAD0 + 32'(i));
      check("fl_dropped", 32'(wb_valid), 32'd0);
    end
    check("fl_ready_after", 32'(issue_ready), 32'd1);
    respond(32'h55);
    check("fl_live_valid", 32'(wb_valid), 32'd1);
    check("fl_live_rd", 32'(wb_rd), 32'd5);
    check("fl_live_data", wb_data, 32'h55);

    // Spurious response with nothing outstanding
    respond(32'h77);
    check("sp_flag", 32'(spurious_error), 32'd1);
    check("sp_no_wb", 32'(wb_valid), 32'd0);
    step();
    step();
    check("sp_sticky", 32'(spurious_error), 32'd1);

    // Async reset in the middle of a transfer
    issue(2'd0, 2'd2, 1'b0, 5'd6);
    respond(32'h1234_5678);
    check("ar_pre_valid", 32'(wb_valid), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("ar_wb_valid", 32'(wb_valid), 32'd0);
    check("ar_wb_data", wb_data, 32'd0);
    check("ar_wb_rd", 32'(wb_rd), 32'd0);
    check("ar_spurious", 32'(spurious_error), 32'd0);
    check("ar_pending", 32'(pending_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
